// File: rtl/alu_pipe_nbit_pkg.sv
// rtl/alu_pipe_nbit_pkg.sv - shared opcode, flag types and helpers for the pipelined ALU
package alu_pipe_nbit_pkg;

  localparam int unsigned OPCODE_W = 3;

  typedef enum logic [OPCODE_W-1:0] {
    OP_ADD      = 3'd0,
    OP_SUB      = 3'd1,
    OP_NOT_A    = 3'd2,
    OP_RED_OR_B = 3'd3,
    OP_AND      = 3'd4,
    OP_OR       = 3'd5,
    OP_XOR      = 3'd6,
    OP_ACC      = 3'd7
  } opcode_e;

  typedef struct packed {
    logic overflow;
    logic carry;
    logic zero;
  } flags_t;

  // Two's-complement overflow of an addition, judged from the operand and result sign bits.
  function automatic logic add_overflow(input logic sign_x, input logic sign_y, input logic sign_r);
    return (sign_x == sign_y) && (sign_r != sign_x);
  endfunction

endpackage

// File: rtl/alu_pipe_nbit_if.sv
// rtl/alu_pipe_nbit_if.sv - operand/result handshake bundle between sequencer, ALU and collector
interface alu_pipe_nbit_if #(
  parameter int WIDTH = 4
);
  import alu_pipe_nbit_pkg::*;

  logic                    in_valid;
  logic                    in_ready;
  opcode_e                 opcode;
  logic signed [WIDTH-1:0] a;
  logic signed [WIDTH-1:0] b;
  logic                    out_valid;
  logic                    out_ready;
  logic signed [WIDTH:0]   result;
  flags_t                  flags;

  modport master (
    output in_valid, opcode, a, b, out_ready,
    input  in_ready, out_valid, result, flags
  );

  modport slave (
    input  in_valid, opcode, a, b, out_ready,
    output in_ready, out_valid, result, flags
  );

endinterface

// File: rtl/alu_datapath.sv
// rtl/alu_datapath.sv - combinational result, flag and next-accumulator computation
module alu_datapath
  import alu_pipe_nbit_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  opcode_e                 opcode,
  input  logic signed [WIDTH-1:0] a,
  input  logic signed [WIDTH-1:0] b,
  input  logic signed [WIDTH:0]   acc,
  output logic signed [WIDTH:0]   result,
  output flags_t                  flags,
  output logic signed [WIDTH:0]   next_acc
);

  logic signed [WIDTH:0] a_ext;
  logic signed [WIDTH:0] b_ext;
  logic signed [WIDTH:0] sum;
  logic signed [WIDTH:0] diff;
  logic signed [WIDTH:0] acc_sum;
  logic        [WIDTH:0] usum;

  always_comb begin
    a_ext   = {a[WIDTH-1], a};
    b_ext   = {b[WIDTH-1], b};
    sum     = a_ext + b_ext;
    diff    = a_ext - b_ext;
    acc_sum = acc + a_ext;
    usum    = {1'b0, a} + {1'b0, b};
  end

  assign next_acc = acc_sum;

  // Overflow for ADD/SUB is judged on the WIDTH-bit result even though the output is WIDTH+1 bits.
  always_comb begin
    result = '0;
    flags  = '0;
    unique case (opcode)
      OP_ADD: begin
        result         = sum;
        flags.carry    = usum[WIDTH];
        flags.overflow = add_overflow(a[WIDTH-1], b[WIDTH-1], sum[WIDTH-1]);
      end
      OP_SUB: begin
        result         = diff;
        flags.carry    = ($unsigned(a) < $unsigned(b));
        flags.overflow = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
      end
      OP_NOT_A:    result = {1'b0, ~a};
      OP_RED_OR_B: result = {{WIDTH{1'b0}}, |b};
      OP_AND:      result = {1'b0, a & b};
      OP_OR:       result = {1'b0, a | b};
      OP_XOR:      result = {1'b0, a ^ b};
      OP_ACC: begin
        result         = acc_sum;
        flags.overflow = add_overflow(acc[WIDTH], a_ext[WIDTH], acc_sum[WIDTH]);
      end
      default: result = '0;
    endcase
    flags.zero = (result == '0);
  end

endmodule

// File: rtl/alu_pipe_nbit.sv
// rtl/alu_pipe_nbit.sv - two-stage pipelined ALU with accumulator and full back-pressure
module alu_pipe_nbit
  import alu_pipe_nbit_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic           clk,
  input  logic           reset,
  alu_pipe_nbit_if.slave bus
);

  logic                    s1_valid;
  opcode_e                 s1_op;
  logic signed [WIDTH-1:0] s1_a;
  logic signed [WIDTH-1:0] s1_b;

  logic                    s2_valid;
  logic signed [WIDTH:0]   s2_result;
  flags_t                  s2_flags;

  logic signed [WIDTH:0]   acc;

  logic                    s2_adv;
  logic                    in_ready;
  logic signed [WIDTH:0]   dp_result;
  flags_t                  dp_flags;
  logic signed [WIDTH:0]   dp_next_acc;

  assign s2_adv   = !s2_valid || bus.out_ready;
  assign in_ready = !s1_valid || s2_adv;

  alu_datapath #(
    .WIDTH (WIDTH)
  ) u_datapath (
    .opcode   (s1_op),
    .a        (s1_a),
    .b        (s1_b),
    .acc      (acc),
    .result   (dp_result),
    .flags    (dp_flags),
    .next_acc (dp_next_acc)
  );

  // The accumulator only commits as an ACC beat leaves S1, so a following ACC already sees it.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid  <= 1'b0;
      s1_op     <= OP_ADD;
      s1_a      <= '0;
      s1_b      <= '0;
      s2_valid  <= 1'b0;
      s2_result <= '0;
      s2_flags  <= '0;
      acc       <= '0;
    end else begin
      if (in_ready) begin
        s1_valid <= bus.in_valid;
        if (bus.in_valid) begin
          s1_op <= bus.opcode;
          s1_a  <= bus.a;
          s1_b  <= bus.b;
        end
      end
      if (s2_adv) begin
        s2_valid <= s1_valid;
        if (s1_valid) begin
          s2_result <= dp_result;
          s2_flags  <= dp_flags;
          if (s1_op == OP_ACC) begin
            acc <= dp_next_acc;
          end
        end
      end
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = s2_valid;
  assign bus.result    = s2_result;
  assign bus.flags     = s2_flags;

endmodule

// File: tb/tb_alu_pipe_nbit.sv
// tb/tb_alu_pipe_nbit.sv - directed-vector bench with arithmetic reference model and scoreboard
module tb_alu_pipe_nbit;
  import alu_pipe_nbit_pkg::*;

  localparam int W = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;

  alu_pipe_nbit_if #(.WIDTH(W)) bus ();

  alu_pipe_nbit #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic [W:0] exp_r[$];
  logic [2:0] exp_f[$];
  logic [W:0] log_r[$];
  logic [2:0] log_f[$];
  int         macc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", name, act, expv);
    end
  endtask

  // Reference: plain integer arithmetic on the operand values, in acceptance order.
  task automatic model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    int sa, sb, ua, ub, n;
    logic c, v;
    logic [W:0] r;
    sa = $signed(a);
    sb = $signed(b);
    ua = int'(a);
    ub = int'(b);
    c = 1'b0;
    v = 1'b0;
    n = 0;
    case (op)
      3'd0: begin
        n = sa + sb;
        c = (ua + ub) >= (1 << W);
        v = (n > (1 << (W-1)) - 1) || (n < -(1 << (W-1)));
      end
      3'd1: begin
        n = sa - sb;
        c = (ua < ub);
        v = (n > (1 << (W-1)) - 1) || (n < -(1 << (W-1)));
      end
      3'd2: n = (~ua) & ((1 << W) - 1);
      3'd3: n = (ub != 0) ? 1 : 0;
      3'd4: n = ua & ub;
      3'd5: n = ua | ub;
      3'd6: n = ua ^ ub;
      default: begin
        n = macc + sa;
        v = (n > (1 << W) - 1) || (n < -(1 << W));
      end
    endcase
    r = n[W:0];
    if (op == 3'd7) macc = $signed(r);
    exp_r.push_back(r);
    exp_f.push_back({v, c, (r == '0)});
  endtask

  logic       prev_stall = 1'b0;
  logic [W:0] prev_r;
  logic [2:0] prev_f;
  logic [W:0] er;
  logic [2:0] ef;

  always @(negedge clk) begin
    #3;
    if (reset) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("stall_valid", 32'(bus.out_valid), 32'd1);
        chk("stall_result", 32'($unsigned(bus.result)), 32'(prev_r));
        chk("stall_flags", 32'(bus.flags), 32'(prev_f));
      end
      if (bus.out_valid && bus.out_ready) begin
        if (exp_r.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_output: got %0h want none", bus.result);
        end else begin
          er = exp_r.pop_front();
          ef = exp_f.pop_front();
          chk("result", 32'($unsigned(bus.result)), 32'(er));
          chk("flags", 32'(bus.flags), 32'(ef));
        end
        log_r.push_back(bus.result);
        log_f.push_back(bus.flags);
      end
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_r     = bus.result;
      prev_f     = bus.flags;
    end
  end

  task automatic step(input logic v, input logic [2:0] op, input logic [W-1:0] a,
                      input logic [W-1:0] b, input logic ordy, output logic took);
    @(negedge clk);
    bus.in_valid  = v;
    bus.opcode    = opcode_e'(op);
    bus.a         = a;
    bus.b         = b;
    bus.out_ready = ordy;
    #4;
    took = v && bus.in_ready;
    if (took) model(op, a, b);
  endtask

  task automatic send(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic ordy);
    logic t;
    t = 1'b0;
    for (int i = 0; i < 50 && !t; i++) step(1'b1, op, a, b, ordy, t);
    if (!t) begin
      n_cmp++;
      n_bad++;
      $display("FAIL send_timeout: got no accept want accept");
    end
  endtask

  task automatic drain();
    logic t;
    for (int i = 0; i < 60 && exp_r.size() != 0; i++) step(1'b0, 3'd0, '0, '0, 1'b1, t);
    chk("drain_empty", 32'(exp_r.size()), 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    exp_r.delete();
    exp_f.delete();
    macc = 0;
    #4;
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_result", 32'($unsigned(bus.result)), 32'd0);
    chk("rst_flags", 32'(bus.flags), 32'd0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
  endtask

  task automatic lit(input string name, input int idx, input logic [W:0] r, input logic [2:0] f);
    if (idx >= log_r.size()) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s: got no output want %0h", name, r);
    end else begin
      chk({name, "_r"}, 32'(log_r[idx]), 32'(r));
      chk({name, "_f"}, 32'(log_f[idx]), 32'(f));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    logic t;
    int base;
    int idx;
    logic [2:0] s_op[4];
    logic [W-1:0] s_a[4];
    logic [W-1:0] s_b[4];

    bus.in_valid  = 1'b0;
    bus.opcode    = OP_ADD;
    bus.a         = '0;
    bus.b         = '0;
    bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    do_reset();

    // ADD 7+1: visible two edges after presentation
    step(1'b1, 3'd0, 4'd7, 4'd1, 1'b1, t);
    chk("add_take", 32'(t), 32'd1);
    step(1'b0, 3'd0, '0, '0, 1'b1, t);
    chk("lat_one_edge", 32'(bus.out_valid), 32'd0);
    step(1'b0, 3'd0, '0, '0, 1'b1, t);
    chk("lat_two_edge", 32'(bus.out_valid), 32'd1);
    chk("add_lit_r", 32'($unsigned(bus.result)), 32'h08);
    chk("add_lit_f", 32'(bus.flags), 32'b100);
    drain();

    base = log_r.size();
    send(3'd1, 4'd0, 4'd1, 1'b1);
    send(3'd4, 4'b1100, 4'b1010, 1'b1);
    drain();
    lit("sub_lit", base, 5'b11111, 3'b010);
    lit("and_lit", base + 1, 5'b01000, 3'b000);

    // Back-to-back ACC with one accept per cycle
    do_reset();
    base = log_r.size();
    step(1'b1, 3'd7, 4'd5, '0, 1'b1, t); chk("acc_take0", 32'(t), 32'd1);
    step(1'b1, 3'd7, 4'd5, '0, 1'b1, t); chk("acc_take1", 32'(t), 32'd1);
    step(1'b1, 3'd7, 4'd5, '0, 1'b1, t); chk("acc_take2", 32'(t), 32'd1);
    step(1'b1, 3'd7, 4'd1, '0, 1'b1, t); chk("acc_take3", 32'(t), 32'd1);
    drain();
    lit("acc0", base,     5'd5,      3'b000);
    lit("acc1", base + 1, 5'd10,     3'b000);
    lit("acc2", base + 2, 5'd15,     3'b000);
    lit("acc3", base + 3, 5'b10000,  3'b100);

    // Four beats against a stalled consumer, then release
    s_op = '{3'd0, 3'd6, 3'd5, 3'd1};
    s_a  = '{4'd3, 4'd5, 4'd1, 4'd2};
    s_b  = '{4'd4, 4'd3, 4'd8, 4'd7};
    base = log_r.size();
    idx  = 0;
    for (int c = 0; c < 6; c++) begin
      step(idx < 4, s_op[idx < 4 ? idx : 0], s_a[idx < 4 ? idx : 0], s_b[idx < 4 ? idx : 0], 1'b0, t);
      if (t) idx++;
    end
    chk("stall_accepts", 32'(idx), 32'd2);
    chk("stall_in_ready", 32'(bus.in_ready), 32'd0);
    for (int c = 0; c < 20 && idx < 4; c++) begin
      step(1'b1, s_op[idx], s_a[idx], s_b[idx], 1'b1, t);
      if (t) idx++;
    end
    chk("release_accepts", 32'(idx), 32'd4);
    drain();
    chk("stall_count", 32'(log_r.size() - base), 32'd4);
    lit("stall0", base,     5'd7,      3'b000);
    lit("stall1", base + 1, 5'd6,      3'b000);
    lit("stall2", base + 2, 5'd9,      3'b000);
    lit("stall3", base + 3, 5'b11011,  3'b010);

    // Reset with both stages occupied discards them
    send(3'd0, 4'd1, 4'd1, 1'b0);
    send(3'd0, 4'd2, 4'd2, 1'b0);
    do_reset();
    base = log_r.size();
    send(3'd7, 4'd3, 4'd0, 1'b1);
    drain();
    chk("post_rst_count", 32'(log_r.size() - base), 32'd1);
    lit("post_rst_acc", base, 5'd3, 3'b000);

    base = log_r.size();
    send(3'd2, 4'b0101, 4'd0, 1'b1);
    send(3'd3, 4'd0, 4'd0, 1'b1);
    send(3'd3, 4'd9, 4'd4, 1'b1);
    drain();
    lit("not_a", base,     5'b01010, 3'b000);
    lit("redor0", base + 1, 5'd0,    3'b001);
    lit("redor1", base + 2, 5'd1,    3'b000);

    repeat (4) step(1'b0, 3'd0, '0, '0, 1'b1, t);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
